// File: rtl/tt_checker_pkg.sv
// Shared definitions for the exhaustive truth-table checker: FSM state codes and
// the binary-to-reflected-Gray conversion used by the vector sequencer.
package tt_checker_pkg;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    // Callers truncate the result to their own vector width.
    function automatic logic [7:0] bin2gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/tt_vec_seq.sv
// Step and dwell counters for the sweep; maps step index to the applied vector
// value in binary or reflected-Gray order.
module tt_vec_seq
    import tt_checker_pkg::*;
#(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned DWELL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            advance,
    input  logic            gray,
    output logic            sample,
    output logic            last,
    output logic [N_IN-1:0] vec,
    output logic [N_IN-1:0] vec_next
);

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [N_IN-1:0] step_q, step_d, step_inc;
    logic [DW-1:0]   dwell_q, dwell_d;

    assign sample   = (dwell_q == DW'(DWELL - 1));
    assign last     = sample && (step_q == {N_IN{1'b1}});
    assign step_inc = step_q + N_IN'(1);
    assign vec      = gray ? N_IN'(bin2gray(8'(step_q))) : step_q;
    assign vec_next = gray ? N_IN'(bin2gray(8'(step_inc))) : step_inc;

    always_comb begin
        step_d  = step_q;
        dwell_d = dwell_q;
        if (load) begin
            step_d  = '0;
            dwell_d = '0;
        end else if (advance) begin
            if (sample) begin
                step_d  = step_inc;
                dwell_d = '0;
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q  <= '0;
            dwell_q <= '0;
        end else begin
            step_q  <= step_d;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/exhaustive_tt_checker.sv
// Exhaustive stimulus engine: sweeps all N_IN-bit vectors, holds each for DWELL
// cycles, and scores the DUT response against a latched expected truth table.
module exhaustive_tt_checker
    import tt_checker_pkg::*;
#(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned OUT_W = 1,
    parameter int unsigned DWELL = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        gray_mode,
    input  logic [OUT_W*(2**N_IN)-1:0]  exp_table,
    output logic [N_IN-1:0]             dut_in,
    input  logic [OUT_W-1:0]            dut_out,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [N_IN:0]               err_count,
    output logic [N_IN-1:0]             first_err_vec,
    output logic                        first_err_valid
);

    localparam int unsigned TW = OUT_W * (2 ** N_IN);
    localparam int unsigned CW = N_IN + 1;

    logic [0:0]      state_q, state_d;
    logic [TW-1:0]   exp_q, exp_d;
    logic            gray_q, gray_d;
    logic [N_IN-1:0] dut_in_q, dut_in_d;
    logic [CW-1:0]   err_q, err_d;
    logic [N_IN-1:0] fev_q, fev_d;
    logic            fval_q, fval_d;
    logic            pass_q, pass_d;
    logic            done_q, done_d;

    logic            load, advance, sample, last, mismatch;
    logic [N_IN-1:0] vec, vec_next;

    tt_vec_seq #(
        .N_IN  (N_IN),
        .DWELL (DWELL)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .advance  (advance),
        .gray     (gray_q),
        .sample   (sample),
        .last     (last),
        .vec      (vec),
        .vec_next (vec_next)
    );

    assign mismatch = (dut_out != exp_q[int'(vec) * OUT_W +: OUT_W]);

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        gray_d   = gray_q;
        dut_in_d = dut_in_q;
        err_d    = err_q;
        fev_d    = fev_q;
        fval_d   = fval_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        load     = 1'b0;
        advance  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    load     = 1'b1;
                    exp_d    = exp_table;
                    gray_d   = gray_mode;
                    err_d    = '0;
                    fev_d    = '0;
                    fval_d   = 1'b0;
                    pass_d   = 1'b0;
                    dut_in_d = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                advance = 1'b1;
                if (sample) begin
                    if (mismatch) begin
                        err_d = err_q + CW'(1);
                        if (!fval_q) begin
                            fev_d  = vec;
                            fval_d = 1'b1;
                        end
                    end
                    if (last) begin
                        // Pass must include the compare made on this final edge.
                        pass_d   = (err_q == '0) && !mismatch;
                        done_d   = 1'b1;
                        dut_in_d = '0;
                        state_d  = StIdle;
                    end else begin
                        dut_in_d = vec_next;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            exp_q    <= '0;
            gray_q   <= 1'b0;
            dut_in_q <= '0;
            err_q    <= '0;
            fev_q    <= '0;
            fval_q   <= 1'b0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            gray_q   <= gray_d;
            dut_in_q <= dut_in_d;
            err_q    <= err_d;
            fev_q    <= fev_d;
            fval_q   <= fval_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
        end
    end

    assign busy            = (state_q == StRun);
    assign done            = done_q;
    assign pass            = pass_q;
    assign dut_in          = dut_in_q;
    assign err_count       = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fval_q;

endmodule

// File: tb/tb_exhaustive_tt_checker.sv
// Bench for exhaustive_tt_checker: two instances (DWELL=1 and DWELL=3) driving a
// majority-gate DUT, checked every cycle against a run-level reference model.
module tb_exhaustive_tt_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_w [2];
    logic       gray_mode;
    logic [7:0] exp_table;
    logic       reg_mode;

    logic [2:0] dut_in_w  [2];
    logic       dut_out_w [2];
    logic       busy_w    [2];
    logic       done_w    [2];
    logic       pass_w    [2];
    logic [3:0] errc_w    [2];
    logic [2:0] fv_w      [2];
    logic       fval_w    [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic maj(input logic [2:0] v);
        return $countones(v) >= 2;
    endfunction

    // Majority DUT, combinational or with one register stage.
    logic maj_q0 = 1'b0;
    logic maj_q1 = 1'b0;
    always @(posedge clk) begin
        maj_q0 <= maj(dut_in_w[0]);
        maj_q1 <= maj(dut_in_w[1]);
    end
    assign dut_out_w[0] = reg_mode ? maj_q0 : maj(dut_in_w[0]);
    assign dut_out_w[1] = maj_q1;

    exhaustive_tt_checker #(.N_IN(3), .OUT_W(1), .DWELL(1)) u_dut0 (
        .clk             (clk),
        .rst             (rst),
        .start           (start_w[0]),
        .gray_mode       (gray_mode),
        .exp_table       (exp_table),
        .dut_in          (dut_in_w[0]),
        .dut_out         (dut_out_w[0]),
        .busy            (busy_w[0]),
        .done            (done_w[0]),
        .pass            (pass_w[0]),
        .err_count       (errc_w[0]),
        .first_err_vec   (fv_w[0]),
        .first_err_valid (fval_w[0])
    );

    exhaustive_tt_checker #(.N_IN(3), .OUT_W(1), .DWELL(3)) u_dut1 (
        .clk             (clk),
        .rst             (rst),
        .start           (start_w[1]),
        .gray_mode       (gray_mode),
        .exp_table       (exp_table),
        .dut_in          (dut_in_w[1]),
        .dut_out         (dut_out_w[1]),
        .busy            (busy_w[1]),
        .done            (done_w[1]),
        .pass            (pass_w[1]),
        .err_count       (errc_w[1]),
        .first_err_vec   (fv_w[1]),
        .first_err_valid (fval_w[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d required %0d", name, $time, act, req);
        end
    endtask

    // Reference model: one whole run is planned at start acceptance.
    bit         busy_m [2];
    bit         done_m [2];
    bit         pass_m [2];
    bit         fval_m [2];
    int         err_m  [2];
    int         fv_m   [2];
    int         k_m    [2];
    int         len_m  [2];
    bit         pe_pass [2];
    bit         pe_fval [2];
    int         pe_err  [2];
    int         pe_fv   [2];
    logic [2:0] dq [2][24];

    function automatic logic [2:0] vec_of(input int s, input bit g);
        return g ? 3'(s ^ (s >> 1)) : 3'(s);
    endfunction

    task automatic model_reset(input int i);
        busy_m[i] = 0; done_m[i] = 0; pass_m[i] = 0; fval_m[i] = 0;
        err_m[i] = 0; fv_m[i] = 0; k_m[i] = 0;
    endtask

    task automatic model_accept(input int i);
        int  dw;
        bit  regd;
        dw   = (i == 0) ? 1 : 3;
        regd = (i == 0) ? reg_mode : 1'b1;
        len_m[i] = 8 * dw;
        for (int c = 0; c < len_m[i]; c++) dq[i][c] = vec_of(c / dw, gray_mode);
        pe_err[i] = 0; pe_fval[i] = 0; pe_fv[i] = 0;
        for (int s = 0; s < 8; s++) begin
            int         c;
            logic [2:0] v, prev;
            logic       resp;
            c    = s * dw + dw - 1;
            v    = dq[i][c];
            prev = (c == 0) ? 3'd0 : dq[i][c-1];
            resp = regd ? maj(prev) : maj(v);
            if (resp != exp_table[v]) begin
                pe_err[i]++;
                if (!pe_fval[i]) begin
                    pe_fv[i]   = int'(v);
                    pe_fval[i] = 1;
                end
            end
        end
        pe_pass[i] = (pe_err[i] == 0);
        busy_m[i] = 1; k_m[i] = 0;
        err_m[i] = 0; fv_m[i] = 0; fval_m[i] = 0; pass_m[i] = 0;
    endtask

    task automatic model_step(input int i);
        if (busy_m[i]) begin
            k_m[i]++;
            if (k_m[i] == len_m[i]) begin
                busy_m[i] = 0; done_m[i] = 1;
                err_m[i] = pe_err[i]; fv_m[i] = pe_fv[i];
                fval_m[i] = pe_fval[i]; pass_m[i] = pe_pass[i];
            end
        end else begin
            done_m[i] = 0;
            if (start_w[i]) model_accept(i);
        end
    endtask

    task automatic model_compare(input int i);
        chk($sformatf("busy%0d", i), busy_w[i], busy_m[i]);
        chk($sformatf("done%0d", i), done_w[i], done_m[i]);
        chk($sformatf("dut_in%0d", i), dut_in_w[i], busy_m[i] ? dq[i][k_m[i]] : 3'd0);
        chk($sformatf("pass%0d", i), pass_w[i], pass_m[i]);
        if (!busy_m[i]) begin
            chk($sformatf("err_count%0d", i), errc_w[i], err_m[i]);
            chk($sformatf("first_err_vec%0d", i), fv_w[i], fv_m[i]);
            chk($sformatf("first_err_valid%0d", i), fval_w[i], fval_m[i]);
        end
    endtask

    // Check the state after the last edge, then advance the model with the
    // inputs the next edge will sample.
    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) model_reset(i);
                model_compare(i);
                if (!rst) model_step(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int i);
        start_w[i] = 1'b1;
        tick(1);
        start_w[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int budget = 60;
        while (busy_w[i] && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) chk("run_timeout", 1, 0);
    endtask

    logic [2:0] gray_seq [8];

    initial begin
        gray_seq = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
        rst = 1'b1;
        start_w[0] = 1'b0;
        start_w[1] = 1'b0;
        gray_mode = 1'b0;
        exp_table = 8'b1110_1000;
        reg_mode  = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("reset_busy", busy_w[0], 0);
        chk("reset_err", errc_w[0], 0);

        // Correct majority table, binary order.
        pulse(0);
        wait_idle(0);
        chk("t1_done", done_w[0], 1);
        chk("t1_pass", pass_w[0], 1);
        chk("t1_err", errc_w[0], 0);
        tick(1);
        chk("t1_done_clear", done_w[0], 0);

        // Single wrong entry at vector 5.
        exp_table = 8'b1100_1000;
        pulse(0);
        wait_idle(0);
        chk("t2_err", errc_w[0], 1);
        chk("t2_fev", fv_w[0], 5);
        chk("t2_fval", fval_w[0], 1);
        chk("t2_pass", pass_w[0], 0);
        tick(1);

        // Gray order; mode and table change mid-run must not matter.
        gray_mode = 1'b1;
        exp_table = 8'b1100_0000;
        pulse(0);
        for (int j = 0; j < 8; j++) chk("t3_model_seq", dq[0][j], gray_seq[j]);
        gray_mode = 1'b0;
        exp_table = 8'hff;
        wait_idle(0);
        chk("t3_err", errc_w[0], 2);
        chk("t3_fev", fv_w[0], 3);
        tick(1);

        // Registered DUT: passes with DWELL=3, fails with DWELL=1.
        exp_table = 8'b1110_1000;
        pulse(1);
        wait_idle(1);
        chk("t4_pass_dwell3", pass_w[1], 1);
        tick(1);
        reg_mode = 1'b1;
        pulse(0);
        wait_idle(0);
        chk("t4_err_dwell1", errc_w[0], 3);
        chk("t4_pass_dwell1", pass_w[0], 0);
        tick(1);
        reg_mode = 1'b0;

        // Reset mid-run at step 4.
        pulse(0);
        tick(4);
        chk("t5_step4", dut_in_w[0], 4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_busy", busy_w[0], 0);
        chk("t5_done", done_w[0], 0);
        chk("t5_dut_in", dut_in_w[0], 0);
        tick(1);
        pulse(0);
        wait_idle(0);
        chk("t5_pass", pass_w[0], 1);
        tick(1);

        // Start held high: ignored while busy, accepted in the done cycle.
        exp_table = 8'b1100_1000;
        start_w[0] = 1'b1;
        tick(1);
        wait_idle(0);
        chk("t6_done", done_w[0], 1);
        chk("t6_err_first", errc_w[0], 1);
        tick(1);
        chk("t6_rebusy", busy_w[0], 1);
        chk("t6_err_cleared", errc_w[0], 0);
        chk("t6_dut_in0", dut_in_w[0], 0);
        start_w[0] = 1'b0;
        wait_idle(0);
        chk("t6_err_second", errc_w[0], 1);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exhaustive_tt_checker.md
Name: exhaustive_tt_checker

Overview:
Self-checking exhaustive stimulus engine for small combinational blocks under test. On start it sweeps every N_IN-bit input vector and holds each for DWELL cycles. It compares the DUT response against an expected truth table and reports pass/fail, error count and the first failing vector. This is the parametrised successor of our fixed 3-input hand-stepped benches, and it can also be instantiated on-chip as a BIST wrapper.

Parameters:
N_IN, 3, number of DUT inputs (1..8); sweep length 2**N_IN vectors
OUT_W, 1, number of DUT outputs compared per vector (1..8)
DWELL, 1, cycles each vector is held; sample taken on last cycle (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  run request; accepted only when busy==0
gray_mode  in  1  sweep order: 0 binary, 1 reflected Gray; latched at start accept
exp_table  in  OUT_W*2**N_IN  expected outputs; slice [v*OUT_W +: OUT_W] = response to vector v; latched at start accept
dut_in  out  N_IN  registered stimulus to DUT
dut_out  in  OUT_W  DUT response (combinational, or registered within DWELL-1 cycles)
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  last run had zero mismatches; valid when busy==0
err_count  out  N_IN+1  mismatching vectors in last run (max 2**N_IN, no saturation needed)
first_err_vec  out  N_IN  vector value (not step index) of first mismatch
first_err_valid  out  1  at least one mismatch in last run

Behaviour:
- Reset (async, any time, incl. mid-run): all outputs 0, FSM IDLE, latched table/mode cleared; no done pulse is generated.
- FSM states: IDLE, RUN. No separate DONE state; done is a pulse on the RUN->IDLE edge.
- IDLE + start=1 at edge: the block latches exp_table and gray_mode and clears err_count, first_err_*, pass. It sets busy=1, step=0, dwell_cnt=0, dut_in=vec(0)=0.
- vec(step) = step when binary; step ^ (step>>1) when Gray.
- RUN, each edge: if dwell_cnt<DWELL-1, dwell_cnt++ and dut_in is held.
- RUN, edge with dwell_cnt==DWELL-1: compare dut_out against exp slice[vec(step)]. On mismatch: err_count++; if first_err_valid==0, set first_err_vec=vec(step) and first_err_valid=1.
- Same edge, if step<2**N_IN-1: step++, dut_in=vec(step+1), dwell_cnt=0.
- Same edge, if step==2**N_IN-1: busy=0, done=1 (one cycle), pass=(no mismatch incl. this compare), dut_in=0, FSM to IDLE.
- busy high for exactly 2**N_IN*DWELL cycles. The final result is visible the cycle done is high.
- start while busy: ignored, with no effect on the run. start in the done cycle (busy==0) is accepted; the next run begins the following cycle.
- Results hold until the next accepted start or rst.
- exp_table/gray_mode changes during a run have no effect because both are latched.

Decomposition:
- Package tt_checker_pkg: FSM state enum {IDLE, RUN}; function bin2gray(N_IN).
- Sub-module tt_vec_seq holds step counter, dwell counter and Gray conversion. Interface: load, advance, last, vec.

Test Plan:
1. N_IN=3, OUT_W=1, DWELL=1, majority DUT, exp_table=8'b1110_1000, gray_mode=0, start pulse -> dut_in 0..7 on consecutive cycles; busy 8 cycles; done one cycle; pass=1, err_count=0, first_err_valid=0.
2. Same DUT, exp_table=8'b1100_1000 (bit 5 wrong) -> err_count=1, first_err_vec=5, first_err_valid=1, pass=0.
3. gray_mode=1, exp_table=8'b1100_0000 (bits 3,5 wrong) -> dut_in sequence 0,1,3,2,6,7,5,4; err_count=2, first_err_vec=3.
4. DWELL=3, majority DUT with 1-cycle registered output -> each vector held 3 cycles, busy 24 cycles, pass=1. Same DUT with DWELL=1 -> pass=0, err_count>0.
5. rst asserted while step=4 -> next cycle all outputs 0, busy=0, no done pulse. A new start then completes a full 8-vector run with pass=1.
6. start held high throughout a run -> no restart while busy. Accepted in the done cycle, so busy rises the next cycle, err_count is cleared, and dut_in restarts at 0.
